compare_result_counter: RTL and testbench
=========================================

Name: compare_result_counter

Overview:
- Downstream consumer of the 4-bit magnitude comparator's a_gt_b / a_eq_b / a_lt_b flags.
- Tallies comparator outcomes over a fixed window of WINDOW valid samples.
- At window end, presents a held summary (gt/eq/lt/error counts) to a downstream reader via a valid/ready handshake.
- Used to characterise operand streams, e.g. a bench stimulus or a sorting front end.

Parameters:
- WINDOW, 8: samples per measurement window; legal range 1..2**CNT_W-1.
- CNT_W, 4: width of every count output; must satisfy 2**CNT_W > WINDOW.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new window; honoured only in IDLE
- in_valid  input  1  comparator flags valid this cycle
- a_gt_b  input  1  comparator flag: a greater than b
- a_eq_b  input  1  comparator flag: a equal to b
- a_lt_b  input  1  comparator flag: a less than b
- busy  output  1  high in COUNT state
- out_valid  output  1  summary available (DONE state)
- out_ready  input  1  downstream accepts summary
- gt_count  output  CNT_W  samples with only a_gt_b set
- eq_count  output  CNT_W  samples with only a_eq_b set
- lt_count  output  CNT_W  samples with only a_lt_b set
- err_count  output  CNT_W  samples whose flags were not exactly one-hot

Behaviour:
- One clock and one reset: clk, with rst synchronous and active-high. All state is registered on the rising edge of clk.
- Reset values: FSM=IDLE; busy=0; out_valid=0; all counts=0; internal sample index=0. rst takes priority over every other input in any state, including mid-window and during DONE; any partial window is discarded.
- FSM has three states: IDLE, COUNT, DONE.
- IDLE:
  - start=1: next cycle enters COUNT, all counts and the index are cleared, busy=1.
  - in_valid is ignored.
  - Counts from the previous window remain readable until start.
- COUNT:
  - Each cycle with in_valid=1 classifies the flags:
    - exactly {gt} -> gt_count+1
    - exactly {eq} -> eq_count+1
    - exactly {lt} -> lt_count+1
    - anything else (000, or two or more set) -> err_count+1
  - The index increments on every accepted sample.
  - Counts are visible the cycle after the sample.
  - When the WINDOW-th sample is accepted, the next cycle enters DONE: out_valid=1, busy=0. Latency from last sample to out_valid is 1 cycle.
  - in_valid=0 cycles are bubbles: no change, no timeout.
  - start is ignored.
- DONE:
  - Counts are frozen; out_valid is held high until out_valid&&out_ready.
  - On the handshake cycle, the next state is IDLE and out_valid drops the following cycle.
  - in_valid and start are ignored in DONE, including on the handshake cycle itself; start must be reissued in IDLE.
- Invariant at DONE: gt_count+eq_count+lt_count+err_count == WINDOW. Counts cannot overflow given the CNT_W rule, so no saturation logic is needed.
- out_ready is a don't-care outside DONE.

Decomposition:
- Shared package holds:
  - state encodings: ST_IDLE=2'd0, ST_COUNT=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE
  - flag-vector index constants: GT=2, EQ=1, LT=0
- One sub-module is natural: compare_flag_decode, purely combinational, maps {a_gt_b,a_eq_b,a_lt_b} to one-hot {is_gt,is_eq,is_lt,is_err}.
- FSM and counters stay in the top module.

Test Plan:
- Reset and idle: rst for 2 cycles, then pulse in_valid with flags 100 while in IDLE -> all counts 0, busy=0, out_valid=0.
- Mixed window: start, then 8 samples 100,100,010,001,001,001,100,010 -> out_valid the cycle after the 8th sample with gt=3, eq=2, lt=3, err=0.
- Bubbles and errors: start, then samples interleaved with in_valid=0 gaps, including flag patterns 000 and 110 -> err_count=2, counts sum to 8, gaps add no counts.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 and start=1 -> counts and out_valid stay unchanged. Raise out_ready -> IDLE; a new start is needed to begin the next window.
- Reset mid-window: after 4 samples, assert rst -> next cycle IDLE with all counts 0. A fresh window then counts correctly from 0.
- Back-to-back windows: handshake and start on consecutive cycles -> second window's counts begin at 0 and match that window's stimulus alone.

Source files
------------

// File: rtl/compare_result_counter_pkg.sv
// Shared constants for the comparator-outcome tally block: FSM encodings,
// flag-vector bit positions and the decoded sample class.
package compare_result_counter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit positions inside the {a_gt_b, a_eq_b, a_lt_b} flag vector
    localparam int GT = 2;
    localparam int EQ = 1;
    localparam int LT = 0;

    typedef struct packed {
        logic is_gt;
        logic is_eq;
        logic is_lt;
        logic is_err;
    } flag_class_t;

endpackage

// File: rtl/compare_result_counter_decode.sv
// Combinational classifier: turns the three comparator flags into exactly one
// of gt / eq / lt / err.
module compare_flag_decode
    import compare_result_counter_pkg::*;
(
    input  logic [2:0]  i_flags,
    output flag_class_t o_class
);

    always_comb begin
        o_class = '0;
        case (i_flags)
            3'b100:  o_class.is_gt  = 1'b1;
            3'b010:  o_class.is_eq  = 1'b1;
            3'b001:  o_class.is_lt  = 1'b1;
            default: o_class.is_err = 1'b1;
        endcase
        // Cross-check against the named bit positions so a reordered vector is caught
        if (o_class.is_gt && !i_flags[GT]) o_class = '{is_gt: 1'b0, is_eq: 1'b0, is_lt: 1'b0, is_err: 1'b1};
        if (o_class.is_eq && !i_flags[EQ]) o_class = '{is_gt: 1'b0, is_eq: 1'b0, is_lt: 1'b0, is_err: 1'b1};
        if (o_class.is_lt && !i_flags[LT]) o_class = '{is_gt: 1'b0, is_eq: 1'b0, is_lt: 1'b0, is_err: 1'b1};
    end

endmodule

// File: rtl/compare_result_counter.sv
// Tallies comparator outcomes over a window of WINDOW valid samples and holds
// the summary for a valid/ready reader.
module compare_result_counter
    import compare_result_counter_pkg::*;
#(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_gt;
    logic [CNT_W-1:0] r_eq;
    logic [CNT_W-1:0] r_lt;
    logic [CNT_W-1:0] r_err;

    logic [2:0]  w_flags;
    flag_class_t w_class;

    assign w_flags = {a_gt_b, a_eq_b, a_lt_b};

    compare_flag_decode u_decode (
        .i_flags (w_flags),
        .o_class (w_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_gt    <= '0;
            r_eq    <= '0;
            r_lt    <= '0;
            r_err   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Previous window's counts stay readable until the next start
                    if (start) begin
                        r_state <= ST_COUNT;
                        r_idx   <= '0;
                        r_gt    <= '0;
                        r_eq    <= '0;
                        r_lt    <= '0;
                        r_err   <= '0;
                    end
                end
                ST_COUNT: begin
                    if (in_valid) begin
                        if (w_class.is_gt)  r_gt  <= r_gt  + ONE;
                        if (w_class.is_eq)  r_eq  <= r_eq  + ONE;
                        if (w_class.is_lt)  r_lt  <= r_lt  + ONE;
                        if (w_class.is_err) r_err <= r_err + ONE;
                        r_idx <= r_idx + ONE;
                        if (r_idx == LAST_IDX) r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == ST_COUNT);
    assign out_valid = (r_state == ST_DONE);
    assign gt_count  = r_gt;
    assign eq_count  = r_eq;
    assign lt_count  = r_lt;
    assign err_count = r_err;

endmodule

// File: tb/tb_compare_result_counter.sv
// Bench for compare_result_counter: fixed window vectors, hand-written corner
// sequences and randomized windows against a queue-based reference.
module tb_compare_result_counter;

    localparam int WIN = 8;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst, start, in_valid, a_gt_b, a_eq_b, a_lt_b, out_ready;
    logic busy, out_valid;
    logic [CW-1:0] gt_count, eq_count, lt_count, err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    compare_result_counter #(.WINDOW(WIN), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .a_lt_b    (a_lt_b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt_count  (gt_count),
        .eq_count  (eq_count),
        .lt_count  (lt_count),
        .err_count (err_count)
    );

    // Sample i of a window lives in flags[3*i +: 3]; gap bit i inserts a bubble before it
    typedef struct packed {
        logic [23:0] flags;
        logic [7:0]  gaps;
        logic [3:0]  gt;
        logic [3:0]  eq;
        logic [3:0]  lt;
        logic [3:0]  err;
    } win_vec_t;

    win_vec_t vecs [4];
    int q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [2:0] f);
        {a_gt_b, a_eq_b, a_lt_b} = f;
    endtask

    task automatic check_counts(input string tag, input int g, input int e, input int l, input int r);
        check({tag, " gt"},  int'(gt_count),  g);
        check({tag, " eq"},  int'(eq_count),  e);
        check({tag, " lt"},  int'(lt_count),  l);
        check({tag, " err"}, int'(err_count), r);
    endtask

    // Reference classification: exactly one flag set decides the class, else error
    function automatic int ref_class(input logic [2:0] f);
        if ($countones(f) != 1) return 3;
        if (f[2]) return 0;
        if (f[1]) return 1;
        return 2;
    endfunction

    function automatic int qcount(input int c);
        int n = 0;
        foreach (q[i]) if (q[i] == c) n++;
        return n;
    endfunction

    task automatic feed(input logic [2:0] f);
        in_valid = 1'b1;
        set_flags(f);
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("handshake out_valid drop", int'(out_valid), 0);
    endtask

    initial begin
        vecs[0] = '{flags: {3'b010,3'b100,3'b001,3'b001,3'b001,3'b010,3'b100,3'b100},
                    gaps: 8'h00, gt: 4'd3, eq: 4'd2, lt: 4'd3, err: 4'd0};
        vecs[1] = '{flags: {3'b001,3'b010,3'b100,3'b001,3'b010,3'b110,3'b100,3'b000},
                    gaps: 8'b1010_1010, gt: 4'd2, eq: 4'd2, lt: 4'd2, err: 4'd2};
        vecs[2] = '{flags: {3'b010,3'b010,3'b010,3'b010,3'b010,3'b101,3'b011,3'b111},
                    gaps: 8'b0000_1111, gt: 4'd0, eq: 4'd5, lt: 4'd0, err: 4'd3};
        vecs[3] = '{flags: {3'b001,3'b001,3'b001,3'b001,3'b100,3'b100,3'b100,3'b100},
                    gaps: 8'b1000_0001, gt: 4'd4, eq: 4'd0, lt: 4'd4, err: 4'd0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_flags(3'b000);
        step();
        step();
        rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset out_valid", int'(out_valid), 0);
        check_counts("reset", 0, 0, 0, 0);

        // in_valid in IDLE must not count
        feed(3'b100);
        step();
        check("idle busy", int'(busy), 0);
        check_counts("idle sample", 0, 0, 0, 0);
        $display("reset/idle: counts=%0d/%0d/%0d/%0d", gt_count, eq_count, lt_count, err_count);

        // Table-driven windows
        for (int v = 0; v < 4; v++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            check("start busy", int'(busy), 1);
            check_counts("start clear", 0, 0, 0, 0);
            for (int s = 0; s < WIN; s++) begin
                logic [23:0] fl;
                fl = vecs[v].flags;
                if (vecs[v].gaps[s]) begin
                    set_flags(3'b100);
                    step();
                end
                feed(fl[3*s +: 3]);
            end
            check("window out_valid", int'(out_valid), 1);
            check("window busy", int'(busy), 0);
            check_counts("window", int'(vecs[v].gt), int'(vecs[v].eq), int'(vecs[v].lt), int'(vecs[v].err));
            $display("window %0d: gt=%0d eq=%0d lt=%0d err=%0d", v, gt_count, eq_count, lt_count, err_count);
            if (v != 0) handshake();
            else begin
                // Backpressure: DONE ignores in_valid and start while out_ready is low
                for (int c = 0; c < 5; c++) begin
                    in_valid = 1'b1; start = 1'b1; set_flags(3'b010);
                    step();
                    check("backpressure out_valid", int'(out_valid), 1);
                end
                check_counts("backpressure", 3, 2, 3, 0);
                in_valid = 1'b0; start = 1'b0;
                handshake();
                for (int c = 0; c < 3; c++) begin
                    in_valid = 1'b1; set_flags(3'b001);
                    step();
                end
                in_valid = 1'b0;
                check("post-handshake busy", int'(busy), 0);
                check_counts("held after handshake", 3, 2, 3, 0);
                $display("backpressure: held and released");
            end
        end

        // Reset mid-window discards partial counts
        start = 1'b1; step(); start = 1'b0;
        for (int s = 0; s < 4; s++) feed(3'b100);
        check("partial gt", int'(gt_count), 4);
        rst = 1'b1; step(); rst = 1'b0;
        check("midreset busy", int'(busy), 0);
        check_counts("midreset", 0, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int s = 0; s < WIN; s++) feed(3'b010);
        check("fresh out_valid", int'(out_valid), 1);
        check_counts("fresh", 0, 8, 0, 0);
        $display("mid-window reset: fresh eq=%0d", eq_count);

        // Handshake and start on consecutive cycles; start during handshake is ignored
        out_ready = 1'b1; start = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b handshake busy", int'(busy), 0);
        check("b2b handshake out_valid", int'(out_valid), 0);
        step();
        start = 1'b0;
        check("b2b start busy", int'(busy), 1);
        check_counts("b2b clear", 0, 0, 0, 0);
        for (int s = 0; s < WIN; s++) feed((s < 2) ? 3'b001 : 3'b000);
        check_counts("b2b", 0, 0, 2, 6);
        $display("back-to-back: lt=%0d err=%0d", lt_count, err_count);
        handshake();

        // Randomized windows vs queue reference
        for (int w = 0; w < 30; w++) begin
            int hold;
            start = 1'b1; step(); start = 1'b0;
            q.delete();
            check("rand start busy", int'(busy), 1);
            while (q.size() < WIN) begin
                logic [2:0] f;
                logic v;
                f = 3'($urandom);
                v = ($urandom_range(0, 2) != 0);
                in_valid = v; start = 1'($urandom); set_flags(f);
                step();
                if (v) q.push_back(ref_class(f));
                check("rand busy", int'(busy), (q.size() < WIN) ? 1 : 0);
                check("rand out_valid", int'(out_valid), (q.size() == WIN) ? 1 : 0);
                check_counts("rand running", qcount(0), qcount(1), qcount(2), qcount(3));
            end
            hold = $urandom_range(0, 3);
            for (int c = 0; c < hold; c++) begin
                in_valid = 1'($urandom); start = 1'($urandom); set_flags(3'($urandom));
                step();
                check("rand hold out_valid", int'(out_valid), 1);
            end
            in_valid = 1'b0; start = 1'b0;
            check_counts("rand final", qcount(0), qcount(1), qcount(2), qcount(3));
            check("rand sum", int'(gt_count) + int'(eq_count) + int'(lt_count) + int'(err_count), WIN);
            $display("random window %0d: gt=%0d eq=%0d lt=%0d err=%0d hold=%0d",
                     w, gt_count, eq_count, lt_count, err_count, hold);
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
